inv_cipher_controller: RTL and testbench

INV_CIPHER_CONTROLLER -- requirements
Module: inv_cipher_controller

---
 rtl/inv_cipher_controller.sv | 161 ++++++++++++++++
 tb/tb_inv_cipher_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv_cipher_controller.sv
// AES-128 inverse cipher: iterative, one inverse round per clock.
// Round keys are fetched combinationally through keyIndex/roundKey.
module inv_cipher_controller #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inValid,
  output logic         inReady,
  input  logic [127:0] cipherText,
  output logic [3:0]   keyIndex,
  input  logic [127:0] roundKey,
  output logic         outValid,
  input  logic         outReady,
  output logic [127:0] plainText,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE, INIT, ROUND, FINAL, DONE
  } st_t;

  st_t          st_q, st_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         ov_q, ov_d;
  logic [127:0] sr_x;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xt(t);
    end
    return p;
  endfunction

  // x^254 is the field inverse (and maps 0 to 0)
  function automatic logic [7:0] gfinv(input logic [7:0] x);
    logic [7:0] p;
    p = x;
    for (int i = 0; i < 6; i++)
      p = gmul(gmul(p, p), x);
    return gmul(p, p);
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gfinv(y);
  endfunction

  function automatic logic [127:0] isr_isb(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] imix(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign sr_x = isr_isb(state_q) ^ roundKey;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    ov_d    = ov_q;
    unique case (st_q)
      IDLE: begin
        if (inValid) begin
          state_d = cipherText ^ roundKey;
          rnd_d   = 4'(NR - 1);
          st_d    = ROUND;
        end
      end
      ROUND: begin
        state_d = imix(sr_x);
        rnd_d   = rnd_q - 4'd1;
        if (rnd_q == 4'd1) st_d = FINAL;
      end
      FINAL: begin
        state_d = sr_x;
        st_d    = DONE;
        ov_d    = 1'b1;
      end
      DONE: begin
        if (outReady) begin
          st_d = IDLE;
          ov_d = 1'b0;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q    <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    keyIndex = 4'd0;
    unique case (st_q)
      IDLE:    keyIndex = 4'(NR);
      ROUND:   keyIndex = rnd_q;
      default: keyIndex = 4'd0;
    endcase
  end

  assign inReady   = (st_q == IDLE);
  assign busy      = (st_q != IDLE);
  assign outValid  = ov_q;
  assign plainText = ov_q ? state_q : '0;

endmodule

// File: tb/tb_inv_cipher_controller.sv
// Directed bench for inv_cipher_controller using FIPS-197 vectors.
// Round keys are expanded locally and served by keyIndex.
module tb_inv_cipher_controller;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         inValid;
  logic         inReady;
  logic [127:0] cipherText;
  logic [3:0]   keyIndex;
  logic [127:0] roundKey;
  logic         outValid;
  logic         outReady;
  logic [127:0] plainText;
  logic         busy;

  logic [127:0] rk [0:10];
  int           n_chk = 0;
  int           n_fail = 0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;

  inv_cipher_controller #(.NR(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .inValid    (inValid),
    .inReady    (inReady),
    .cipherText (cipherText),
    .keyIndex   (keyIndex),
    .roundKey   (roundKey),
    .outValid   (outValid),
    .outReady   (outReady),
    .plainText  (plainText),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign roundKey = (keyIndex <= 4'd10) ? rk[keyIndex] : '0;

  function automatic logic [7:0] b_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] b_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = b_xt(t);
    end
    return p;
  endfunction

  // forward S-box: brute-force inverse, then affine map
  function automatic logic [7:0] b_sbox(input logic [7:0] x);
    logic [7:0] v;
    v = '0;
    for (int y = 1; y < 256; y++)
      if (b_mul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
         ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {b_sbox(t[31:24]), b_sbox(t[23:16]),
             b_sbox(t[15:8]), b_sbox(t[7:0])} ^ {rc, 24'h0};
        rc = b_xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // offer one block, wait for outValid, check result and key order
  task automatic run_block(
    input string        tag,
    input logic [127:0] ct,
    input logic [127:0] exp,
    input bit           poke
  );
    int cnt;
    bit ki_ok;
    @(negedge clk);
    inValid    = 1'b1;
    cipherText = ct;
    chk({tag, "_inready"}, inReady, 1'b1);
    chk({tag, "_key10"}, keyIndex, 4'd10);
    @(negedge clk);
    inValid = 1'b0;
    cnt     = 0;
    ki_ok   = 1'b1;
    while (!outValid && cnt < 30) begin
      if (keyIndex !== 4'(9 - cnt)) ki_ok = 1'b0;
      inValid    = poke && (cnt == 3 || cnt == 4);
      cipherText = poke ? '1 : ct;
      @(negedge clk);
      cnt++;
    end
    inValid = 1'b0;
    chk({tag, "_latency"}, cnt, 10);
    chk({tag, "_keyseq"}, ki_ok, 1'b1);
    chk({tag, "_pt"}, plainText, exp);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_inready_lo"}, inReady, 1'b0);
  endtask

  task automatic release_out(input string tag);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    chk({tag, "_ov_clr"}, outValid, 1'b0);
    chk({tag, "_idle"}, inReady, 1'b1);
    chk({tag, "_pt_zero"}, plainText, 128'h0);
  endtask

  initial begin
    bit stable;
    bit quiet;
    reset_n    = 1'b0;
    inValid    = 1'b0;
    outReady   = 1'b0;
    cipherText = '0;
    expand(K1);
    #3;
    chk("rst_ov", outValid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key", keyIndex, 4'd10);
    chk("rst_pt", plainText, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rel_inready", inReady, 1'b1);

    // outReady with no valid output must do nothing
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    chk("idle_ordy_ov", outValid, 1'b0);
    chk("idle_ordy_busy", busy, 1'b0);

    run_block("c1", C1, P1, 1'b0);

    // hold output for 20 cycles, with a stray inValid
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      inValid    = (i == 7);
      cipherText = 128'hdeadbeef;
      @(negedge clk);
      if (plainText !== P1 || outValid !== 1'b1 ||
          busy !== 1'b1 || inReady !== 1'b0)
        stable = 1'b0;
    end
    inValid = 1'b0;
    chk("hold_stable", stable, 1'b1);
    release_out("c1");
    chk("c1_busy_clr", busy, 1'b0);

    run_block("ign", C1, P1, 1'b1);
    release_out("ign");

    // reset in the 5th ROUND cycle aborts the block
    expand(K2);
    @(negedge clk);
    inValid    = 1'b1;
    cipherText = C2;
    @(negedge clk);
    inValid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_ov", outValid, 1'b0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_key", keyIndex, 4'd10);
    chk("mid_pt", plainText, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (outValid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("mid_abort", quiet, 1'b1);

    run_block("appb", C2, P2, 1'b0);
    release_out("appb");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
